ahb_rr_arbiter: RTL and testbench

Four-master round-robin AHB bus arbiter with burst-length tracking, optional locked-transfer support and a per-grant watchdog. It sits between the master ports and the address/write-data muxes, replacing fixed-priority two-master arbitration. It drives one-hot grants, the granted master index and the slave select for the mux network. Grant ownership is counted in completed beats, not single transfers.

---
 rtl/ahb_rr_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter
//
// Four-master round-robin AHB bus arbiter. Ownership of the bus is held for a
// whole burst, counted in completed beats (hready_out high with no error),
// and is released on the final beat, on an ERROR response, or when the
// per-grant watchdog expires. One dead (HANDOVER) cycle always separates two
// owners. The next owner is the first requesting master found searching
// upward from the previous owner + 1, with wrap.
//
// Optional feature macro: ARB_LOCK_EN
//   Defined   : a master holding hlock at the normal end of its burst keeps
//               the grant with no gap. The beat counter and sel are reloaded
//               from its current hlen / hsel_in.
//   Undefined : hlock is ignored.
//
// Parameters
//   TIMEOUT     GRANT cycles without a completed beat before forced release
//               (2..65535)
//
// Ports
//   hclk        bus clock, rising edge
//   hresetn     asynchronous active-low reset
//   hreq[3:0]   request per master
//   hlock[3:0]  lock request per master (ARB_LOCK_EN only)
//   hlen[15:0]  beats-1 per master, hlen[4m+3:4m]
//   hsel_in[7:0] slave select per master, hsel_in[2m+1:2m]
//   hready_out  ready from the selected slave
//   hresp       error response from the selected slave (1 = ERROR)
//   hgrant[3:0] one-hot grant (registered)
//   hmaster[1:0] index of the granted master (registered)
//   sel[1:0]    slave select to the mux network (registered)
//   busy        high while in GRANT (registered)
//   timeout     one-cycle pulse in the HANDOVER cycle after a watchdog release

module ahb_rr_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [3:0]  hreq,
  input  logic [3:0]  hlock,
  input  logic [15:0] hlen,
  input  logic [7:0]  hsel_in,
  input  logic        hready_out,
  input  logic        hresp,
  output logic [3:0]  hgrant,
  output logic [1:0]  hmaster,
  output logic [1:0]  sel,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    HANDOVER = 2'd2
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] wdog_q, wdog_d;
  logic [1:0]  last_q, last_d;

  logic [3:0]  hgrant_d;
  logic [1:0]  hmaster_d;
  logic [1:0]  sel_d;
  logic        busy_d;
  logic        timeout_d;

  logic        beat_done;
  logic        any_req;
  logic [1:0]  winner;

`ifndef ARB_LOCK_EN
  logic        unused_hlock;
  assign unused_hlock = ^hlock;
`endif

  // Round-robin search: first set request bit strictly after lst, wrapping,
  // so lst itself is considered last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] lst);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    idx   = lst;
    res   = lst;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = idx + 2'd1;
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign beat_done = busy && hready_out && !hresp;
  assign any_req   = |hreq;
  assign winner    = rr_pick(hreq, last_q);

  // Next-state and next-output logic. Outputs are computed here and
  // registered below so that they are glitch-free toward the mux network.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wdog_d    = wdog_q;
    last_d    = last_q;
    hgrant_d  = hgrant;
    hmaster_d = hmaster;
    sel_d     = sel;
    busy_d    = busy;
    timeout_d = 1'b0;

    case (state_q)
      IDLE, HANDOVER: begin
        if (any_req) begin
          state_d   = GRANT;
          hgrant_d  = 4'b0001 << winner;
          hmaster_d = winner;
          sel_d     = hsel_in[2*winner +: 2];
          cnt_d     = hlen[4*winner +: 4];
          last_d    = winner;
          wdog_d    = '0;
          busy_d    = 1'b1;
        end else begin
          state_d   = IDLE;
          hgrant_d  = '0;
          sel_d     = '0;
          busy_d    = 1'b0;
        end
      end

      GRANT: begin
        if (hresp) begin
          // Error end takes priority over both the count and the watchdog.
          state_d  = HANDOVER;
          hgrant_d = '0;
          sel_d    = '0;
          busy_d   = 1'b0;
        end else if (beat_done) begin
          wdog_d = '0;
          if (cnt_q == 4'd0) begin
`ifdef ARB_LOCK_EN
            if (hlock[hmaster]) begin
              cnt_d = hlen[4*hmaster +: 4];
              sel_d = hsel_in[2*hmaster +: 2];
            end else begin
              state_d  = HANDOVER;
              hgrant_d = '0;
              sel_d    = '0;
              busy_d   = 1'b0;
            end
`else
            state_d  = HANDOVER;
            hgrant_d = '0;
            sel_d    = '0;
            busy_d   = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else if (wdog_q == WDOG_LAST) begin
          // Cycle number TIMEOUT of a stalled grant: force release.
          state_d   = HANDOVER;
          hgrant_d  = '0;
          sel_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end

      default: begin
        state_d  = IDLE;
        hgrant_d = '0;
        sel_d    = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wdog_q  <= '0;
      last_q  <= 2'd3;
      hgrant  <= '0;
      hmaster <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      last_q  <= last_d;
      hgrant  <= hgrant_d;
      hmaster <= hmaster_d;
      sel     <= sel_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
module tb_ahb_rr_arbiter;

  logic        hclk;
  logic        hresetn;
  logic [3:0]  hreq;
  logic [3:0]  hlock;
  logic [15:0] hlen;
  logic [7:0]  hsel_in;
  logic        hready_out;
  logic        hresp;
  logic [3:0]  hgrant;
  logic [1:0]  hmaster;
  logic [1:0]  sel;
  logic        busy;
  logic        timeout;

  int tests_run = 0;
  int tests_failed = 0;

  ahb_rr_arbiter #(.TIMEOUT(64)) dut (
    .hclk(hclk), .hresetn(hresetn), .hreq(hreq), .hlock(hlock),
    .hlen(hlen), .hsel_in(hsel_in), .hready_out(hready_out), .hresp(hresp),
    .hgrant(hgrant), .hmaster(hmaster), .sel(sel), .busy(busy),
    .timeout(timeout)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic [7:0]  hs;
    logic        rdy;
    logic        rsp;
    logic [3:0]  eg;
    logic [1:0]  em;
    logic [1:0]  es;
    logic        eb;
    logic        et;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg,
                         input logic [1:0] em, input logic [1:0] es,
                         input logic eb, input logic et);
    chk({tag, ".hgrant"},  {28'd0, hgrant},  {28'd0, eg});
    chk({tag, ".hmaster"}, {30'd0, hmaster}, {30'd0, em});
    chk({tag, ".sel"},     {30'd0, sel},     {30'd0, es});
    chk({tag, ".busy"},    {31'd0, busy},    {31'd0, eb});
    chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, et});
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  int n;

  initial begin
    // Single burst for master 0 (4 beats, sel 2), then idle.
    vt[0]  = '{4'b0001, 16'h0003, 8'h02, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd2, 1'b1, 1'b0};
    vt[1]  = '{4'b0000, 16'h0003, 8'h02, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd2, 1'b1, 1'b0};
    vt[2]  = '{4'b0000, 16'h0003, 8'h02, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd2, 1'b1, 1'b0};
    vt[3]  = '{4'b0000, 16'h0003, 8'h02, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd2, 1'b1, 1'b0};
    vt[4]  = '{4'b0000, 16'h0003, 8'h02, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0};
    vt[5]  = '{4'b0000, 16'h0003, 8'h02, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0};
    // All four requesting, single beats: rotation from master 1 with dead cycles.
    vt[6]  = '{4'b1111, 16'h0000, 8'he4, 1'b1, 1'b0, 4'b0010, 2'd1, 2'd1, 1'b1, 1'b0};
    vt[7]  = '{4'b1111, 16'h0000, 8'he4, 1'b1, 1'b0, 4'b0000, 2'd1, 2'd0, 1'b0, 1'b0};
    vt[8]  = '{4'b1111, 16'h0000, 8'he4, 1'b1, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b1, 1'b0};
    vt[9]  = '{4'b1111, 16'h0000, 8'he4, 1'b1, 1'b0, 4'b0000, 2'd2, 2'd0, 1'b0, 1'b0};
    vt[10] = '{4'b1111, 16'h0000, 8'he4, 1'b1, 1'b0, 4'b1000, 2'd3, 2'd3, 1'b1, 1'b0};
    vt[11] = '{4'b1111, 16'h0000, 8'he4, 1'b1, 1'b0, 4'b0000, 2'd3, 2'd0, 1'b0, 1'b0};
    vt[12] = '{4'b1111, 16'h0000, 8'he4, 1'b1, 1'b0, 4'b0001, 2'd0, 2'd0, 1'b1, 1'b0};
    vt[13] = '{4'b1111, 16'h0000, 8'he4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0};
    vt[14] = '{4'b0000, 16'h0000, 8'he4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0};
    vt[15] = '{4'b0000, 16'h0000, 8'he4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0};

    hresetn = 1'b0; hreq = '0; hlock = '0; hlen = '0; hsel_in = '0;
    hready_out = 1'b0; hresp = 1'b0;
    tick(); tick();
    chk_all("reset", 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0);
    @(negedge hclk);
    hresetn = 1'b1;
    #1;

    for (int i = 0; i < 16; i++) begin
      hreq = vt[i].req; hlen = vt[i].len; hsel_in = vt[i].hs;
      hready_out = vt[i].rdy; hresp = vt[i].rsp;
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].eg, vt[i].em, vt[i].es,
              vt[i].eb, vt[i].et);
    end

    // Error on the 3rd beat of an 8-beat burst from master 1.
    hreq = 4'b0010; hlen = 16'h0070; hsel_in = 8'he4; hready_out = 1'b1; hresp = 1'b0;
    tick();
    chk_all("err.grant", 4'b0010, 2'd1, 2'd1, 1'b1, 1'b0);
    hreq = 4'b0000;
    tick();
    chk_all("err.beat1", 4'b0010, 2'd1, 2'd1, 1'b1, 1'b0);
    tick();
    chk_all("err.beat2", 4'b0010, 2'd1, 2'd1, 1'b1, 1'b0);
    hresp = 1'b1;
    tick();
    chk_all("err.end", 4'b0000, 2'd1, 2'd0, 1'b0, 1'b0);
    hresp = 1'b0;
    tick();
    chk_all("err.idle", 4'b0000, 2'd1, 2'd0, 1'b0, 1'b0);

    // Watchdog: master 2 stalled with hready_out low.
    hreq = 4'b0100; hready_out = 1'b0;
    tick();
    chk_all("wdog.grant", 4'b0100, 2'd2, 2'd2, 1'b1, 1'b0);
    hreq = 4'b0000;
    n = 0;
    do begin
      tick();
      n++;
    end while (hgrant != 4'b0000 && n < 200);
    chk("wdog.cycles", n, 64);
    chk_all("wdog.release", 4'b0000, 2'd2, 2'd0, 1'b0, 1'b1);
    tick();
    chk_all("wdog.after", 4'b0000, 2'd2, 2'd0, 1'b0, 1'b0);
    hready_out = 1'b1;

    // Lock: master 0 (2-beat bursts) with master 1 also requesting.
    hreq = 4'b0011; hlen = 16'h00F1; hlock = 4'b0001;
    tick();
    chk_all("lock.grant", 4'b0001, 2'd0, 2'd0, 1'b1, 1'b0);
`ifdef ARB_LOCK_EN
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("lock.hold%0d", i), {28'd0, hgrant}, 32'h1);
    end
    hlock = 4'b0000;
    tick();
    chk("lock.last_beat", {28'd0, hgrant}, 32'h1);
`else
    tick();
    chk("nolock.beat1", {28'd0, hgrant}, 32'h1);
`endif
    tick();
    chk_all("lock.handover", 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0);
    tick();
    chk_all("lock.next", 4'b0010, 2'd1, 2'd1, 1'b1, 1'b0);
    hreq = 4'b0000; hlock = 4'b0000;
    tick();
    chk_all("rst.midburst", 4'b0010, 2'd1, 2'd1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of master 1's 16-beat burst.
    #2;
    hresetn = 1'b0;
    #1;
    chk_all("rst.async", 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0);
    @(negedge hclk);
    hresetn = 1'b1;
    hreq = 4'b0010;
    tick();
    chk_all("rst.regrant", 4'b0010, 2'd1, 2'd1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
